inst_fetch_seq: RTL
===================

Name: inst_fetch_seq

Overview:
Upstream neighbour of the instruction decoder. Holds the program counter and fetches each instruction from instruction memory over a req/ready handshake. It presents the instruction word with a one-cycle dec_en pulse, then waits for the control unit to signal completion. It then advances or redirects the PC from the branch/jump offsets the decoder produced, and stops on EBREAK (halt) or a misaligned target.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
imem_req  out  1  fetch request, held high until accepted
imem_addr  out  32  fetch address, always equals pc
imem_ready  in  1  memory has imem_rdata valid this cycle
imem_rdata  in  32  instruction word
inst  out  32  latched instruction, feeds decoder
dec_en  out  1  one-cycle decode strobe (decoder acts on its rising edge)
exec_done  in  1  control unit finished current instruction (one-cycle pulse)
branch_taken  in  1  BEQ resolved taken, valid with exec_done
branch_address  in  32  signed byte offset from decoder
jump_taken  in  1  JAL executing, valid with exec_done
jump_address  in  32  signed byte offset from decoder
halt  in  1  HALT (EBREAK) executing, valid with exec_done
pc  out  32  address of current instruction
link_pc  out  32  pc+4, JAL writeback value
halted  out  1  core stopped
fault  out  1  misaligned redirect target detected
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset values: pc=RESET_PC, inst=0, dec_en=0, imem_req=0, halted=0, fault=0, retired=0, state=FETCH. Reset overrides everything, including mid-handshake; an imem_ready arriving in or after the reset cycle for the aborted fetch is ignored.
- States: FETCH, DECODE, EXEC, HALTED.
- FETCH: imem_req=1. Ready is sampled only while req is high. Combinational same-cycle ready is legal. On imem_ready: inst<=imem_rdata, go DECODE. Minimum fetch latency is 1 cycle.
- DECODE: dec_en=1 for exactly one cycle. inst is stable from the cycle before dec_en rises until the next FETCH completes. Go to EXEC.
- EXEC: wait for exec_done, ignoring all other inputs until then. On exec_done, evaluate in priority order:
  1. halt: halted<=1, pc unchanged, go HALTED.
  2. jump_taken: target=pc+jump_address.
  3. branch_taken: target=pc+branch_address.
  4. otherwise target=pc+4.
- Jump beats branch when both are asserted.
- Arithmetic is 32-bit modulo 2^32. Wrap past 0xFFFF_FFFC is legal, no fault.
- If target[1:0]!=0: fault<=1, halted<=1, pc unchanged, go HALTED. Otherwise pc<=target, go FETCH.
- retired increments by 1 on every exec_done in EXEC, including the halting one, but not a faulting one. It wraps at 2^CNT_W.
- HALTED: imem_req=0, dec_en=0, all inputs ignored. Only rst exits.
- link_pc is combinational pc+4.
- exec_done outside EXEC is ignored.

Decomposition:
- Shared package cpu_pkg holds the state encoding (FETCH, DECODE, EXEC, HALTED), XLEN=32, INST_W=32, and the PC increment constant 4. The decoder's opcode and one-hot execution constants move to the same package.
- Sub-module pc_next_sel (combinational target select plus alignment check) is natural. The FSM and registers stay in inst_fetch_seq.

Test Plan:
- Reset release, memory returns 32'h0000_0013 one cycle after req -> imem_addr=0; inst=0x13; dec_en high exactly one cycle; after exec_done pc=4, retired=1, next req at addr 4.
- Same-cycle ready (imem_ready tied high) -> FETCH lasts one cycle; sequence FETCH, DECODE, EXEC repeats with no lost or duplicated dec_en.
- pc=0x10, exec_done with branch_taken and branch_address=0xFFFF_FFF8 -> pc=0x08; with branch_taken=0 -> pc=0x14.
- pc=0x20, exec_done with jump_taken, jump_address=0x100, and branch_taken=1 also asserted -> link_pc=0x24 before update, pc=0x120 (branch ignored).
- exec_done with halt=1 at pc=0x40 -> halted=1, pc=0x40, imem_req stays 0 for 20 cycles, retired increments once; a target of 0x12 in a separate run -> fault=1, halted=1, retired not incremented.
- Assert rst while in FETCH with req high, then pulse imem_ready -> next cycle imem_req=0, pc=RESET_PC, inst=0; after rst drops, a fresh fetch from RESET_PC completes normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared core types, widths, fetch state encoding and decoder constants.
package cpu_pkg;
    localparam int XLEN   = 32;
    localparam int INST_W = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALTED} fetch_state_t;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam int EXEC_W = 6;
    localparam logic [EXEC_W-1:0] EX_ALU    = 6'b000001;
    localparam logic [EXEC_W-1:0] EX_LOAD   = 6'b000010;
    localparam logic [EXEC_W-1:0] EX_STORE  = 6'b000100;
    localparam logic [EXEC_W-1:0] EX_BRANCH = 6'b001000;
    localparam logic [EXEC_W-1:0] EX_JUMP   = 6'b010000;
    localparam logic [EXEC_W-1:0] EX_HALT   = 6'b100000;
    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: picks the next pc (jump over branch over sequential) and flags misaligned targets.
import cpu_pkg::*;
module pc_next_sel (
    input  logic [XLEN-1:0] pc,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_address,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_address,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);
    always_comb begin
        target     = jump_taken ? pc + jump_address : branch_taken ? pc + branch_address : pc + PC_INC;
        misaligned = !is_aligned(target);
    end
endmodule

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: pc register and fetch/decode/execute sequencer ahead of the decoder.
import cpu_pkg::*;
module inst_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ready,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              dec_en,
    input  logic              exec_done,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   branch_address,
    input  logic              jump_taken,
    input  logic [XLEN-1:0]   jump_address,
    input  logic              halt,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   link_pc,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  retired
);
    fetch_state_t    state;
    logic [XLEN-1:0] target;
    logic            misaligned;

    pc_next_sel u_sel (
        .pc             (pc),
        .jump_taken     (jump_taken),
        .jump_address   (jump_address),
        .branch_taken   (branch_taken),
        .branch_address (branch_address),
        .target         (target),
        .misaligned     (misaligned)
    );

    assign imem_addr = pc;
    assign link_pc   = pc + PC_INC;

    // dec_en is raised from DECODE so inst has already been stable for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            inst     <= '0;
            dec_en   <= 1'b0;
            imem_req <= 1'b0;
            halted   <= 1'b0;
            fault    <= 1'b0;
            retired  <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (!imem_req) imem_req <= 1'b1;
                    else if (imem_ready) begin
                        inst     <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    dec_en <= 1'b1;
                    state  <= EXEC;
                end
                EXEC: begin
                    dec_en <= 1'b0;
                    if (exec_done) begin
                        if (halt) begin
                            halted  <= 1'b1;
                            retired <= retired + CNT_W'(1);
                            state   <= HALTED;
                        end else if (misaligned) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= HALTED;
                        end else begin
                            pc       <= target;
                            retired  <= retired + CNT_W'(1);
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end
                HALTED: begin
                    imem_req <= 1'b0;
                    dec_en   <= 1'b0;
                end
            endcase
        end
    end
endmodule
